chain_dp_sched: RTL and testbench
=================================

CHAIN_DP_SCHED -- requirements
Module: chain_dp_sched

Interface
REQ-001 SHALL have parameter IDX_W, 32, width of anchor index and count.
REQ-002 SHALL have parameter LOC_W, 32, width of anchor tag and x coordinate (signed).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to chain one read.
REQ-006 SHALL have port n  input  IDX_W  anchor count, sampled on accepted start.
REQ-007 SHALL have port max_dist_x  input  LOC_W  x-distance limit (default 5000), sampled on accepted start.
REQ-008 SHALL have port max_iter  input  IDX_W  predecessor cap per anchor, sampled on accepted start.
REQ-009 SHALL have port anc_addr  output  IDX_W  anchor memory read address.
REQ-010 SHALL have port anc_rd  output  1  read strobe; data is returned exactly 1 cycle later.
REQ-011 SHALL have port anc_tag / anc_x  input  LOC_W each  tag and x of the addressed anchor.
REQ-012 SHALL have port pair_valid / pair_ready  output / input  1  pair handshake to scoring unit.
REQ-013 SHALL have port pair_i / pair_j  output  IDX_W  current anchor and candidate predecessor.
REQ-014 SHALL have port pair_last / pair_empty  output  1  last pair of row i / row i has no predecessor.
REQ-015 SHALL have port row_done  input  1  pulse from scorer: f/p/t/v for row i written.
REQ-016 SHALL have port busy / done  output  1  read in progress / one-cycle completion pulse.

Function
REQ-017 SHALL accept start only in IDLE; start while busy is ignored.
REQ-018 SHALL run FSM IDLE -> LOAD_I -> ADV_ST -> ISSUE -> WAIT_ROW -> (LOAD_I | FIN) -> IDLE.
REQ-019 SHALL, with n=0, go IDLE -> FIN and pulse done 2 cycles after start, issuing no pairs.
REQ-020 SHALL in LOAD_I read a[i], starting with i=0, st=0.
REQ-021 SHALL in ADV_ST read a[st] while st<i, incrementing st when a[st].tag != a[i].tag or a[i].x - a[st].x > max_dist_x; it SHALL stop at the first st that fails this test or at st=i.
REQ-022 SHALL compute x difference in LOC_W+1 signed bits, so there is no overflow at extreme coordinates.
REQ-023 SHALL never decrement st within a read; st is monotonic.
REQ-024 SHALL in ISSUE emit j = i-1 down to lo = max(st, i-max_iter), one per accepted handshake; pair_last=1 on j=lo.
REQ-025 SHALL, if st=i or max_iter=0, emit one beat with pair_empty=1, pair_last=1, pair_j=0.
REQ-026 SHALL hold pair_* stable while pair_valid=1 and pair_ready=0.
REQ-027 SHALL in WAIT_ROW wait for row_done, then i++ (LOAD_I) or, if i=n-1, enter FIN.
REQ-028 SHALL treat row_done arriving in the same cycle as the last pair handshake as valid, without losing it.
REQ-029 SHALL ignore row_done outside ISSUE/WAIT_ROW.
REQ-030 SHALL in FIN pulse done for 1 cycle; busy=1 from the cycle after start through FIN.

Reset
REQ-031 SHALL on rst, at any time including mid-row, enter IDLE with i=st=0 and all outputs 0 (pair_valid, anc_rd, busy, done, addresses, indices).
REQ-032 SHALL not emit a pair_valid beat or a done pulse in the cycle after rst is released.

Structure
REQ-033 SHALL take loc_t, tag_t, anchor_t, INT32_WIDTH, MAX_ANCHORS and default constants (5000, 5000, 50) from shared package chain_pkg.
REQ-034 SHALL place the j countdown and lo computation in sub-module chain_pair_gen; st tracking and the FSM stay at top level.

Verification
REQ-035 The bench SHALL cover: n=0, start -> done 2 cycles later, no pair_valid.
REQ-036 The bench SHALL cover: n=3, one tag, x={0,100,200}, max_iter=50 -> pairs (0,empty),(1,0 last),(2,1),(2,0 last).
REQ-037 The bench SHALL cover: x={0,6000,6100}, max_dist_x=5000 -> row 1 empty, row 2 emits only (2,1) last.
REQ-038 The bench SHALL cover: tags {1,1,2,2} -> row 2 empty, row 3 emits only (3,2).
REQ-039 The bench SHALL cover: n=60, max_iter=50, random pair_ready backpressure -> row 59 emits j=58..9, stable under stall.
REQ-040 The bench SHALL cover: rst asserted mid-ISSUE -> next cycle IDLE with outputs 0, then a new start completes correctly.

Source files
------------

// File: rtl/chain_pkg.sv
// Shared chaining types and defaults: anchor record layout, FSM state encoding
// and the default chaining limits used by the scheduler.
package chain_pkg;

  localparam int INT32_WIDTH = 32;
  localparam int MAX_ANCHORS = 65536;

  localparam int DEF_MAX_DIST_X = 5000;
  localparam int DEF_MAX_DIST_Y = 5000;
  localparam int DEF_MAX_ITER   = 50;

  typedef logic signed [INT32_WIDTH-1:0] loc_t;
  typedef logic        [INT32_WIDTH-1:0] tag_t;

  typedef struct packed {
    tag_t tag;
    loc_t x;
  } anchor_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_ADV_ST,
    S_ISSUE,
    S_WAIT_ROW,
    S_FIN
  } state_t;

endpackage

// File: rtl/chain_pair_gen.sv
// Predecessor pair generator for one row: counts j down from i-1 to
// lo = max(st, i-max_iter), or emits a single empty beat when the window is empty.
module chain_pair_gen #(
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_i,
  input  logic [IDX_W-1:0] i_st,
  input  logic [IDX_W-1:0] i_max_iter,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j,
  output logic             o_last,
  output logic             o_empty,
  output logic             o_fire_last
);

  logic             r_valid;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_lo;
  logic             r_last;
  logic             r_empty;

  logic [IDX_W-1:0] w_span;
  logic [IDX_W-1:0] w_lo;
  logic             w_empty;
  logic             w_fire;

  // Comparing max_iter against the window size avoids a negative i-max_iter.
  assign w_span  = i_i - i_st;
  assign w_lo    = (i_max_iter >= w_span) ? i_st : (i_i - i_max_iter);
  assign w_empty = (i_st == i_i) || (i_max_iter == '0);
  assign w_fire  = r_valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_lo    <= '0;
      r_last  <= 1'b0;
      r_empty <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_i     <= i_i;
      r_lo    <= w_lo;
      if (w_empty) begin
        r_j     <= '0;
        r_last  <= 1'b1;
        r_empty <= 1'b1;
      end else begin
        r_j     <= i_i - IDX_W'(1);
        r_last  <= ((i_i - IDX_W'(1)) == w_lo);
        r_empty <= 1'b0;
      end
    end else if (w_fire) begin
      if (r_last) begin
        r_valid <= 1'b0;
      end else begin
        r_j    <= r_j - IDX_W'(1);
        r_last <= ((r_j - IDX_W'(1)) == r_lo);
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_i         = r_i;
  assign o_j         = r_j;
  assign o_last      = r_last;
  assign o_empty     = r_empty;
  assign o_fire_last = w_fire && r_last;

endmodule

// File: rtl/chain_dp_sched.sv
// Chaining scheduler: walks the anchors of one read, advances the monotonic window
// start st, and hands (i, j) predecessor pairs to the scoring unit row by row.
module chain_dp_sched
  import chain_pkg::*;
#(
  parameter int IDX_W = INT32_WIDTH,
  parameter int LOC_W = INT32_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic        [IDX_W-1:0] n,
  input  logic signed [LOC_W-1:0] max_dist_x,
  input  logic        [IDX_W-1:0] max_iter,
  output logic        [IDX_W-1:0] anc_addr,
  output logic                    anc_rd,
  input  logic        [LOC_W-1:0] anc_tag,
  input  logic signed [LOC_W-1:0] anc_x,
  output logic                    pair_valid,
  input  logic                    pair_ready,
  output logic        [IDX_W-1:0] pair_i,
  output logic        [IDX_W-1:0] pair_j,
  output logic                    pair_last,
  output logic                    pair_empty,
  input  logic                    row_done,
  output logic                    busy,
  output logic                    done
);

  state_t                  r_state;
  logic                    r_phase;
  logic        [IDX_W-1:0] r_i;
  logic        [IDX_W-1:0] r_st;
  logic        [IDX_W-1:0] r_n;
  logic        [IDX_W-1:0] r_max_iter;
  logic signed [LOC_W-1:0] r_max_dist;
  logic        [LOC_W-1:0] r_tag_i;
  logic signed [LOC_W-1:0] r_x_i;
  logic                    r_anc_rd;
  logic        [IDX_W-1:0] r_anc_addr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pg_load;
  logic                    r_row_seen;

  logic signed [LOC_W:0]   w_dx;
  logic signed [LOC_W:0]   w_max_dist;
  logic                    w_skip;
  logic                    w_last_row;
  logic                    w_fire_last;
  logic                    w_row_adv;

  // One extra bit keeps the x difference exact even at opposite coordinate extremes.
  assign w_dx       = {r_x_i[LOC_W-1], r_x_i} - {anc_x[LOC_W-1], anc_x};
  assign w_max_dist = {r_max_dist[LOC_W-1], r_max_dist};
  assign w_skip     = (anc_tag != r_tag_i) || (w_dx > w_max_dist);
  assign w_last_row = (r_i == (r_n - IDX_W'(1)));

  // A row_done latched earlier in ISSUE, or coincident with the last beat, closes the row.
  assign w_row_adv = ((r_state == S_ISSUE) && w_fire_last && (row_done || r_row_seen)) ||
                     ((r_state == S_WAIT_ROW) && row_done);

  chain_pair_gen #(
    .IDX_W(IDX_W)
  ) u_pair_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_pg_load),
    .i_i        (r_i),
    .i_st       (r_st),
    .i_max_iter (r_max_iter),
    .i_ready    (pair_ready),
    .o_valid    (pair_valid),
    .o_i        (pair_i),
    .o_j        (pair_j),
    .o_last     (pair_last),
    .o_empty    (pair_empty),
    .o_fire_last(w_fire_last)
  );

  // Reads take two cycles per anchor: strobe phase, then data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_phase    <= 1'b0;
      r_i        <= '0;
      r_st       <= '0;
      r_n        <= '0;
      r_max_iter <= '0;
      r_max_dist <= '0;
      r_tag_i    <= '0;
      r_x_i      <= '0;
      r_anc_rd   <= 1'b0;
      r_anc_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pg_load  <= 1'b0;
      r_row_seen <= 1'b0;
    end else begin
      r_anc_rd  <= 1'b0;
      r_done    <= 1'b0;
      r_pg_load <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n        <= n;
            r_max_dist <= max_dist_x;
            r_max_iter <= max_iter;
            r_i        <= '0;
            r_st       <= '0;
            r_busy     <= 1'b1;
            r_row_seen <= 1'b0;
            r_phase    <= 1'b0;
            if (n == '0) begin
              r_state <= S_FIN;
            end else begin
              r_state    <= S_LOAD_I;
              r_anc_rd   <= 1'b1;
              r_anc_addr <= '0;
            end
          end
        end

        S_LOAD_I: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_tag_i <= anc_tag;
            r_x_i   <= anc_x;
            if (r_st < r_i) begin
              r_state    <= S_ADV_ST;
              r_anc_rd   <= 1'b1;
              r_anc_addr <= r_st;
            end else begin
              r_state    <= S_ISSUE;
              r_pg_load  <= 1'b1;
              r_row_seen <= 1'b0;
            end
          end
        end

        S_ADV_ST: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (w_skip && ((r_st + IDX_W'(1)) < r_i)) begin
              r_st       <= r_st + IDX_W'(1);
              r_anc_rd   <= 1'b1;
              r_anc_addr <= r_st + IDX_W'(1);
            end else begin
              if (w_skip) begin
                r_st <= r_st + IDX_W'(1);
              end
              r_state    <= S_ISSUE;
              r_pg_load  <= 1'b1;
              r_row_seen <= 1'b0;
            end
          end
        end

        S_ISSUE: begin
          if (row_done) begin
            r_row_seen <= 1'b1;
          end
          if (w_fire_last && !(row_done || r_row_seen)) begin
            r_state <= S_WAIT_ROW;
          end
        end

        S_WAIT_ROW: begin
          r_state <= S_WAIT_ROW;
        end

        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_row_adv) begin
        r_row_seen <= 1'b0;
        if (w_last_row) begin
          r_state <= S_FIN;
        end else begin
          r_i        <= r_i + IDX_W'(1);
          r_state    <= S_LOAD_I;
          r_phase    <= 1'b0;
          r_anc_rd   <= 1'b1;
          r_anc_addr <= r_i + IDX_W'(1);
        end
      end
    end
  end

  assign anc_rd   = r_anc_rd;
  assign anc_addr = r_anc_addr;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_chain_dp_sched.sv
// Self-checking bench for chain_dp_sched: a reference chaining model fills a
// scoreboard of expected pairs that is drained as the DUT hands pairs out.
module tb_chain_dp_sched;
  import chain_pkg::*;

  localparam int IDX_W = INT32_WIDTH;
  localparam int LOC_W = INT32_WIDTH;
  localparam int MEM_D = 64;
  localparam int BUDGET = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [IDX_W-1:0] n;
  logic [LOC_W-1:0] max_dist_x;
  logic [IDX_W-1:0] max_iter;
  logic [IDX_W-1:0] anc_addr;
  logic             anc_rd;
  logic [LOC_W-1:0] anc_tag = '0;
  logic [LOC_W-1:0] anc_x = '0;
  logic             pair_valid;
  logic             pair_ready;
  logic [IDX_W-1:0] pair_i;
  logic [IDX_W-1:0] pair_j;
  logic             pair_last;
  logic             pair_empty;
  logic             row_done;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;

  anchor_t      mem [0:MEM_D-1];
  logic [127:0] expQ[$];

  chain_dp_sched #(
    .IDX_W(IDX_W),
    .LOC_W(LOC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .max_dist_x(max_dist_x),
    .max_iter  (max_iter),
    .anc_addr  (anc_addr),
    .anc_rd    (anc_rd),
    .anc_tag   (anc_tag),
    .anc_x     (anc_x),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .pair_i    (pair_i),
    .pair_j    (pair_j),
    .pair_last (pair_last),
    .pair_empty(pair_empty),
    .row_done  (row_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Anchor memory with one-cycle read latency.
  always @(posedge clk) begin
    if (anc_rd) begin
      anc_tag <= mem[anc_addr % MEM_D].tag;
      anc_x   <= mem[anc_addr % MEM_D].x;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] packPair(input int i, input int j, input bit last, input bit empty);
    logic [31:0] iv;
    logic [31:0] jv;
    iv = i;
    jv = j;
    return {62'b0, iv, jv, last, empty};
  endfunction

  // Reference chaining: st only moves forward; j runs i-1 down to max(st, i-max_iter).
  task automatic buildExpected(input int nn, input longint maxd, input int mi);
    int st;
    int lo;
    st = 0;
    for (int i = 0; i < nn; i++) begin
      while (st < i && (mem[st].tag != mem[i].tag ||
             (longint'($signed(mem[i].x)) - longint'($signed(mem[st].x))) > maxd))
        st++;
      if (st == i || mi == 0) begin
        expQ.push_back(packPair(i, 0, 1'b1, 1'b1));
      end else begin
        lo = (i - mi > st) ? i - mi : st;
        for (int j = i - 1; j >= lo; j--)
          expQ.push_back(packPair(i, j, j == lo, 1'b0));
      end
    end
  endtask

  task automatic applyStimulus(input int nn, input int maxd, input int mi, input int readyPct,
                               input int abortBeats, output int lat, output int validCnt);
    int cycles;
    int beats;
    int rowDelay;
    bit doneSeen;
    bit stall;
    logic [127:0] snap;
    logic [127:0] got;
    expQ.delete();
    buildExpected(nn, maxd, mi);
    n          = nn;
    max_dist_x = maxd;
    max_iter   = mi;
    start      = 1'b1;
    cycles = 0; beats = 0; rowDelay = -1; doneSeen = 0; stall = 0;
    lat = 0; validCnt = 0; snap = '0;
    while (!doneSeen && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
      start    = 1'b0;
      row_done = 1'b0;
      got = {62'b0, pair_i, pair_j, pair_last, pair_empty};
      if (cycles == 1)
        checkOutput("busy_after_start", busy, 1);
      if (cycles == 5 && nn > 0) begin
        checkOutput("busy_mid", busy, 1);
        start = 1'b1;
        n     = 0;
      end
      if (stall)
        checkOutput("stall_hold", {pair_valid, got}, {1'b1, snap});
      if (done) begin
        doneSeen = 1;
        lat      = cycles;
      end else begin
        if (pair_valid) validCnt++;
        if (rowDelay == 0) begin
          row_done = 1'b1;
          rowDelay = -1;
        end else if (rowDelay > 0) begin
          rowDelay--;
        end
        pair_ready = ($urandom_range(0, 99) < readyPct);
        if (pair_valid && pair_ready) begin
          beats++;
          if (expQ.size() == 0) begin
            checkOutput("pair_extra", expQ.size(), 1);
          end else begin
            checkOutput("pair", got, expQ.pop_front());
          end
          if (pair_last) begin
            rowDelay = $urandom_range(0, 3);
            if (rowDelay == 0) begin
              row_done = 1'b1;
              rowDelay = -1;
            end
          end
        end
        stall = pair_valid && !pair_ready;
        snap  = got;
        if (abortBeats > 0 && beats >= abortBeats) return;
      end
    end
    checkOutput("done_seen", doneSeen, 1);
    row_done   = 1'b0;
    pair_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", {done, busy}, 0);
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  task automatic setLinear(input int cnt, input int tag, input int step);
    for (int k = 0; k < MEM_D; k++) begin
      mem[k].tag = tag;
      mem[k].x   = (k < cnt) ? k * step : 0;
    end
  endtask

  int lat;
  int vcnt;

  initial begin
    rst = 1'b1; start = 1'b0; n = '0; max_dist_x = '0; max_iter = '0;
    pair_ready = 1'b0; row_done = 1'b0;
    setLinear(0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_ctl", {pair_valid, anc_rd, busy, done, pair_last, pair_empty}, 0);
    checkOutput("reset_idx", {pair_i, pair_j, anc_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset", {pair_valid, done, busy}, 0);

    applyStimulus(0, DEF_MAX_DIST_X, DEF_MAX_ITER, 100, 0, lat, vcnt);
    checkOutput("n0_latency", lat, 2);
    checkOutput("n0_no_pairs", vcnt, 0);

    setLinear(3, 1, 100);
    applyStimulus(3, DEF_MAX_DIST_X, DEF_MAX_ITER, 100, 0, lat, vcnt);

    mem[0].x = 0; mem[1].x = 6000; mem[2].x = 6100;
    applyStimulus(3, DEF_MAX_DIST_X, DEF_MAX_ITER, 70, 0, lat, vcnt);

    setLinear(4, 1, 10);
    mem[2].tag = 2; mem[3].tag = 2;
    applyStimulus(4, DEF_MAX_DIST_X, DEF_MAX_ITER, 80, 0, lat, vcnt);

    setLinear(2, 5, 0);
    mem[0].x = 32'h8000_0000; mem[1].x = 32'h7fff_ffff;
    applyStimulus(2, DEF_MAX_DIST_X, DEF_MAX_ITER, 100, 0, lat, vcnt);
    mem[0].x = 32'h7fff_ffff; mem[1].x = 32'h8000_0000;
    applyStimulus(2, DEF_MAX_DIST_X, DEF_MAX_ITER, 100, 0, lat, vcnt);

    setLinear(3, 1, 100);
    applyStimulus(3, DEF_MAX_DIST_X, 0, 100, 0, lat, vcnt);

    setLinear(60, 3, 10);
    applyStimulus(60, DEF_MAX_DIST_X, DEF_MAX_ITER, 60, 0, lat, vcnt);

    applyStimulus(60, DEF_MAX_DIST_X, DEF_MAX_ITER, 60, 20, lat, vcnt);
    rst = 1'b1; start = 1'b0; pair_ready = 1'b0; row_done = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ctl", {pair_valid, anc_rd, busy, done, pair_last, pair_empty}, 0);
    checkOutput("midrst_idx", {pair_i, pair_j, anc_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_release", {pair_valid, done, busy}, 0);
    setLinear(3, 1, 100);
    applyStimulus(3, DEF_MAX_DIST_X, DEF_MAX_ITER, 90, 0, lat, vcnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
